// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment scan controller:
// FSM state encoding and active-high {g,f,e,d,c,b,a} glyph patterns.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEAD = 2'd1,
    ST_ON   = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BCD [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [7:0] SEG_OFF_N = 8'hFF;

endpackage

// File: rtl/seg_decode.sv
// BCD nibble to active-low {dp,g,f,e,d,c,b,a} pattern; non-BCD codes show a dash.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  input  logic       i_dp,
  output logic [7:0] o_seg_n
);

  logic [6:0] w_seg;

  // The decimal point is kept out of the blanking decision on purpose.
  always_comb begin
    w_seg = SEG_DASH;
    if (i_blank) begin
      w_seg = '0;
    end else if (i_nibble <= 4'd9) begin
      w_seg = SEG_BCD[i_nibble];
    end
  end

  assign o_seg_n = ~{i_dp, w_seg};

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scanner: per digit a dark gap then a lit slot,
// decoding from a per-frame snapshot so the counter chain never tears a frame.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NDIG     = 6,
  parameter int SCAN_DIV = 50000,
  parameter int DEAD_CYC = 500
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [4*NDIG-1:0] digits,
  input  logic [NDIG-1:0]   dp,
  input  logic              blank_lz,
  output logic [7:0]        seg_n,
  output logic [NDIG-1:0]   an_n,
  output logic [2:0]        scan_idx,
  output logic              frame_done
);

  localparam int MAXC = (SCAN_DIV > DEAD_CYC) ? SCAN_DIV : DEAD_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYC - 1);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [2:0]    LAST_IDX  = 3'(NDIG - 1);

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [2:0]          r_idx;
  logic [4*NDIG-1:0]   r_snapDigits;
  logic [NDIG-1:0]     r_snapDp;
  logic                r_snapBlank;
  logic [7:0]          r_segN;
  logic [NDIG-1:0]     r_anN;
  logic                r_frameDone;

  state_t              w_nextState;
  logic [2:0]          w_nextIdx;
  logic                w_takeSnap;
  logic                w_wrap;
  logic [4*NDIG-1:0]   w_srcDigits;
  logic [NDIG-1:0]     w_srcDp;
  logic                w_srcBlank;
  logic [3:0]          w_nibble;
  logic                w_dpBit;
  logic                w_blank;
  logic [7:0]          w_decSegN;

  always_comb begin
    w_nextState = r_state;
    w_nextIdx   = r_idx;
    w_takeSnap  = 1'b0;
    w_wrap      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (en) begin
          w_nextState = ST_DEAD;
          w_nextIdx   = 3'd0;
          w_takeSnap  = 1'b1;
        end
      end
      ST_DEAD: begin
        if (!en) begin
          w_nextState = ST_IDLE;
          w_nextIdx   = 3'd0;
        end else if (r_cnt == DEAD_LAST) begin
          w_nextState = ST_ON;
        end
      end
      ST_ON: begin
        if (!en) begin
          w_nextState = ST_IDLE;
          w_nextIdx   = 3'd0;
        end else if (r_cnt == SCAN_LAST) begin
          w_nextState = ST_DEAD;
          if (r_idx == LAST_IDX) begin
            w_nextIdx  = 3'd0;
            w_takeSnap = 1'b1;
            w_wrap     = 1'b1;
          end else begin
            w_nextIdx = r_idx + 3'd1;
          end
        end
      end
      default: begin
        w_nextState = ST_IDLE;
        w_nextIdx   = 3'd0;
      end
    endcase
  end

  // On a snapshot edge the pattern registered alongside must come from the
  // live inputs, since the snapshot registers only update at that same edge.
  assign w_srcDigits = w_takeSnap ? digits   : r_snapDigits;
  assign w_srcDp     = w_takeSnap ? dp       : r_snapDp;
  assign w_srcBlank  = w_takeSnap ? blank_lz : r_snapBlank;

  always_comb begin
    w_nibble = 4'd0;
    w_dpBit  = 1'b0;
    w_blank  = w_srcBlank && (w_nextIdx != 3'd0);
    for (int k = 0; k < NDIG; k++) begin
      if (3'(k) == w_nextIdx) begin
        w_nibble = w_srcDigits[4*k +: 4];
        w_dpBit  = w_srcDp[k];
      end
      if ((3'(k) >= w_nextIdx) && (w_srcDigits[4*k +: 4] != 4'd0)) begin
        w_blank = 1'b0;
      end
    end
  end

  seg_decode u_decode (
    .i_nibble (w_nibble),
    .i_blank  (w_blank),
    .i_dp     (w_dpBit),
    .o_seg_n  (w_decSegN)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_idx        <= 3'd0;
      r_snapDigits <= '0;
      r_snapDp     <= '0;
      r_snapBlank  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_idx   <= w_nextIdx;
      if ((w_nextState != r_state) || (w_nextState == ST_IDLE)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_takeSnap) begin
        r_snapDigits <= digits;
        r_snapDp     <= dp;
        r_snapBlank  <= blank_lz;
      end
    end
  end

  // Outputs are registered from the next-state view so they line up with r_state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_segN      <= SEG_OFF_N;
      r_anN       <= '1;
      r_frameDone <= 1'b0;
    end else begin
      r_segN      <= (w_nextState == ST_IDLE) ? SEG_OFF_N : w_decSegN;
      r_anN       <= (w_nextState == ST_ON) ? ~(NDIG'(1) << w_nextIdx) : '1;
      r_frameDone <= w_wrap;
    end
  end

  assign seg_n      = r_segN;
  assign an_n       = r_anN;
  assign scan_idx   = r_idx;
  assign frame_done = r_frameDone;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a frame-position reference model predicts
// every cycle's outputs into a queue that a negedge monitor drains and compares.
module tb_seg_scan_ctrl;

  localparam int NDIG     = 4;
  localparam int SCAN_DIV = 4;
  localparam int DEAD_CYC = 1;
  localparam int SLOT     = DEAD_CYC + SCAN_DIV;
  localparam int FRAME    = NDIG * SLOT;

  localparam logic [6:0] GLYPH [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dp = '0;
  logic        blankLz = 1'b0;
  logic [7:0]  segN;
  logic [3:0]  anN;
  logic [2:0]  scanIdx;
  logic        frameDone;

  typedef struct {
    logic [3:0] anN;
    logic [7:0] segN;
    logic [2:0] idx;
    logic       fd;
  } expect_t;

  expect_t expQ[$];
  int nVectors = 0;
  int nMiscompares = 0;

  bit          mRun = 1'b0;
  int          mPos = 0;
  bit          mWrap = 1'b0;
  logic [15:0] mSnapDigits = '0;
  logic [3:0]  mSnapDp = '0;
  bit          mSnapBlank = 1'b0;

  seg_scan_ctrl #(
    .NDIG     (NDIG),
    .SCAN_DIV (SCAN_DIV),
    .DEAD_CYC (DEAD_CYC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .digits     (digits),
    .dp         (dp),
    .blank_lz   (blankLz),
    .seg_n      (segN),
    .an_n       (anN),
    .scan_idx   (scanIdx),
    .frame_done (frameDone)
  );

  always #5 clk = ~clk;

  // Reference: position within the frame decides digit and dark/lit phase.
  task automatic modelEdge();
    if (reset) begin
      mRun = 1'b0;
    end else if (!mRun) begin
      if (en) begin
        mRun = 1'b1;
        mPos = 0;
        mWrap = 1'b0;
        mSnapDigits = digits;
        mSnapDp = dp;
        mSnapBlank = blankLz;
      end
    end else if (!en) begin
      mRun = 1'b0;
    end else begin
      mPos++;
      mWrap = 1'b0;
      if (mPos == FRAME) begin
        mPos = 0;
        mWrap = 1'b1;
        mSnapDigits = digits;
        mSnapDp = dp;
        mSnapBlank = blankLz;
      end
    end
  endtask

  function automatic expect_t predict();
    expect_t e;
    int digit;
    int phase;
    logic [15:0] upper;
    logic [3:0] nib;
    logic [6:0] seg7;
    e.anN = 4'hF;
    e.segN = 8'hFF;
    e.idx = 3'd0;
    e.fd = 1'b0;
    if (mRun) begin
      digit = mPos / SLOT;
      phase = mPos % SLOT;
      upper = mSnapDigits >> (4 * digit);
      nib = upper[3:0];
      seg7 = (nib > 4'd9) ? 7'h40 : GLYPH[nib];
      if (mSnapBlank && digit != 0 && upper == 16'h0) seg7 = 7'h00;
      e.segN = ~{mSnapDp[digit], seg7};
      e.anN = (phase < DEAD_CYC) ? 4'hF : ~(4'b0001 << digit);
      e.idx = 3'(digit);
      e.fd = mWrap && (mPos == 0);
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic nEn, input logic [15:0] nDigits,
                               input logic [3:0] nDp, input logic nBlank,
                               input logic nReset);
    @(posedge clk);
    #1;
    modelEdge();
    en = nEn;
    digits = nDigits;
    dp = nDp;
    blankLz = nBlank;
    reset = nReset;
    if (nReset) mRun = 1'b0;
    expQ.push_back(predict());
  endtask

  task automatic hold(input int n);
    repeat (n) applyStimulus(en, digits, dp, blankLz, reset);
  endtask

  task automatic waitPos(input int target);
    int n;
    n = 0;
    while (!(mRun && mPos == target) && n < 4 * FRAME) begin
      hold(1);
      n++;
    end
    if (!(mRun && mPos == target)) begin
      $display("[TB] FAIL waitPos: frame position %0d not reached, model pos %0d", target, mPos);
      nMiscompares++;
    end
  endtask

  function automatic logic [15:0] randDigits();
    logic [15:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) begin
      if ($urandom_range(0, 1) == 1) v[4*k +: 4] = 4'($urandom_range(0, 15));
    end
    return v;
  endfunction

  task automatic checkOutput(input expect_t e);
    bit bad;
    bad = 1'b0;
    nVectors++;
    if (anN !== e.anN) begin
      $display("[TB] FAIL an_n @%0t: got %b, want %b", $time, anN, e.anN);
      bad = 1'b1;
    end
    if (segN !== e.segN) begin
      $display("[TB] FAIL seg_n @%0t: got %h, want %h", $time, segN, e.segN);
      bad = 1'b1;
    end
    if (scanIdx !== e.idx) begin
      $display("[TB] FAIL scan_idx @%0t: got %0d, want %0d", $time, scanIdx, e.idx);
      bad = 1'b1;
    end
    if (frameDone !== e.fd) begin
      $display("[TB] FAIL frame_done @%0t: got %b, want %b", $time, frameDone, e.fd);
      bad = 1'b1;
    end
    if (bad) nMiscompares++;
  endtask

  always @(negedge clk) begin
    if (expQ.size() != 0) checkOutput(expQ.pop_front());
  end

  initial begin
    #2 reset = 1'b1;
    repeat (3) applyStimulus(1'b0, 16'h0, 4'h0, 1'b0, 1'b1);

    applyStimulus(1'b1, 16'h1234, 4'h0, 1'b0, 1'b0);
    hold(2 * FRAME + 3);

    applyStimulus(1'b1, 16'h0050, 4'h0, 1'b1, 1'b0);
    hold(2 * FRAME);
    applyStimulus(1'b1, 16'h0000, 4'h0, 1'b1, 1'b0);
    hold(2 * FRAME);

    // Change the counter value mid-frame; the old value must persist until the wrap.
    applyStimulus(1'b1, 16'h0009, 4'h0, 1'b0, 1'b0);
    hold(FRAME);
    waitPos(2 * SLOT);
    applyStimulus(1'b1, 16'h0010, 4'h0, 1'b0, 1'b0);
    hold(2 * FRAME);

    applyStimulus(1'b1, 16'h00AF, 4'b0100, 1'b1, 1'b0);
    hold(2 * FRAME);
    applyStimulus(1'b1, 16'h00AF, 4'b0100, 1'b0, 1'b0);
    hold(2 * FRAME);

    waitPos(2 * SLOT + 2);
    applyStimulus(1'b0, 16'h1234, 4'h0, 1'b0, 1'b0);
    hold(3);
    applyStimulus(1'b1, 16'h1234, 4'h0, 1'b0, 1'b0);
    hold(FRAME + 5);

    waitPos(SLOT - 1);
    applyStimulus(1'b1, 16'h1234, 4'h0, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'h1234, 4'h0, 1'b0, 1'b0);
    hold(2 * FRAME + 2);

    for (int i = 0; i < 800; i++) begin
      logic [15:0] nDigits;
      logic [3:0]  nDp;
      logic        nBlank;
      logic        nEn;
      logic        nReset;
      nDigits = ($urandom_range(0, 7) == 0) ? randDigits() : digits;
      nDp     = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : dp;
      nBlank  = ($urandom_range(0, 15) == 0) ? ~blankLz : blankLz;
      nEn     = ($urandom_range(0, 59) != 0);
      nReset  = ($urandom_range(0, 199) == 0);
      applyStimulus(nEn, nDigits, nDp, nBlank, nReset);
    end

    for (int n = 0; n < 10 && expQ.size() != 0; n++) @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      $display("[TB] FAIL drain: %0d expectations left unchecked, want 0", expQ.size());
      nMiscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete, %0d vectors so far", nVectors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
